// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pwm_capture_pkg
// Purpose : Shared types for the PWM capture block (measurement FSM states).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package pwm_capture_pkg;

  // IDLE: no reference rising edge yet (after reset or loss of signal).
  // HIGH: input high since the reference rise, waiting for the fall.
  // LOW : input low, waiting for the rise that closes the period.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage : pwm_capture_pkg
`default_nettype wire

// File: rtl/pwm_capture_if.sv
`default_nettype none
// ============================================================================
// Module  : pwm_capture_if
// Purpose : Bundles the PWM input and the measurement result signals.
// Ports   : pwm_in    - asynchronous PWM waveform
//           period    - cycles between the last two rising edges
//           high_time - cycles high within that period
//           valid     - one-cycle pulse when period/high_time update
//           timeout   - level, no complete period within 2^W-1 cycles
// Modports: master - the capture block (drives results)
//           slave  - the consumer (drives pwm_in, reads results)
// Rev     : 1.0  initial release
// ============================================================================
interface pwm_capture_if #(
  parameter int W = 27
) ();

  logic         pwm_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;

  modport master (
    input  pwm_in,
    output period,
    output high_time,
    output valid,
    output timeout
  );

  modport slave (
    output pwm_in,
    input  period,
    input  high_time,
    input  valid,
    input  timeout
  );

endinterface : pwm_capture_if
`default_nettype wire

// File: rtl/pwm_capture_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module  : sync_2ff
// Purpose : Generic two-flop synchronizer for a single asynchronous input.
// Ports   : clk   - destination clock
//           rst_n - asynchronous active-low reset (output clears to 0)
//           d_i   - asynchronous input
//           q_o   - synchronized output, two clk edges of latency
// Rev     : 1.0  initial release
// ============================================================================
module sync_2ff (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic d_i,
  output logic      q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module  : pwm_capture
// Purpose : Measures period and high time of a PWM waveform in clk cycles,
//           publishing one (period, high_time) pair per input period and
//           flagging loss of signal.
// Ports   : clk   - system clock
//           rst_n - asynchronous active-low reset
//           bus   - pwm_capture_if.master (pwm_in in; period, high_time,
//                   valid, timeout out; all outputs registered)
// Rev     : 1.0  initial release
// ============================================================================
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int W = 27
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  pwm_capture_if.master bus
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic         pwm_sync;
  logic         prev_q;
  logic         rise;
  logic         fall;
  logic         cnt_sat;
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  state_t       state_q;
  logic [W-1:0] hi_tmp_q;
  logic [W-1:0] period_q;
  logic [W-1:0] high_time_q;
  logic         valid_q;
  logic         timeout_q;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.pwm_in),
    .q_o   (pwm_sync)
  );

  // Both edges are detected from the same synchronized stream, so they see
  // identical latency and the measured counts are exact.
  assign rise    = pwm_sync & ~prev_q;
  assign fall    = ~pwm_sync & prev_q;
  assign cnt_sat = (cnt_q == CNT_MAX);

  // Free-running cycle counter, restarted at 1 on every rise so that its
  // value at the next edge equals the number of cycles elapsed.
  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = CNT_ONE;
    end else if (!cnt_sat) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= 1'b0;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      hi_tmp_q    <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      prev_q  <= pwm_sync;
      cnt_q   <= cnt_d;
      valid_q <= 1'b0;
      case (state_q)
        // The first rise only starts a reference; the partial period before
        // it is never reported.
        ST_IDLE: begin
          if (rise) begin
            state_q <= ST_HIGH;
          end
        end
        // An edge takes priority over saturation arriving in the same cycle.
        ST_HIGH: begin
          if (fall) begin
            hi_tmp_q <= cnt_q;
            state_q  <= ST_LOW;
          end else if (cnt_sat) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        ST_LOW: begin
          if (rise) begin
            period_q    <= cnt_q;
            high_time_q <= hi_tmp_q;
            valid_q     <= 1'b1;
            timeout_q   <= 1'b0;
            state_q     <= ST_HIGH;
          end else if (cnt_sat) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_time_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;

endmodule : pwm_capture
`default_nettype wire
